// File: rtl/branch_switch_pc_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// branch_switch_pc_sequencer_pkg
//
// Shared definitions for the branch-network switch PC sequencer slice.
//
// Contents:
//   - Configuration-type opcodes used by the upstream branch switch
//     configuration reader. 11 = pc_max, 12 = pc_loop, 13 = net_mem.
//   - calc_thread_w(): derives the thread-id width from the thread count.
//   - ITER_W: width of the optional per-thread loop iteration counter.
//   - Reset values for the output stage (conf_valid / conf_* fields).
//
// Optional feature macro used by the files importing this package:
//   BRANCH_LOOP_COUNT_EN
// ---------------------------------------------------------------------------
package branch_switch_pc_sequencer_pkg;

    // Width of the configuration-type field in the reader's command stream.
    localparam int CFG_TYPE_W = 4;

    // Configuration-type opcodes. The reader decodes these into the
    // pc_max_we / pc_loop_we / net_mem_we strobes this block consumes.
    typedef enum logic [CFG_TYPE_W-1:0] {
        CFG_PC_MAX  = 4'd11,
        CFG_PC_LOOP = 4'd12,
        CFG_NET_MEM = 4'd13
    } branch_cfg_type_e;

    localparam logic [CFG_TYPE_W-1:0] OP_PC_MAX  = 4'd11;
    localparam logic [CFG_TYPE_W-1:0] OP_PC_LOOP = 4'd12;
    localparam logic [CFG_TYPE_W-1:0] OP_NET_MEM = 4'd13;

    // Loop iteration counter width (only used with BRANCH_LOOP_COUNT_EN).
    localparam int ITER_W = 16;

    // Output-stage reset values. Every conf_* field clears to zero and the
    // valid flag drops, so downstream never sees a stale word after reset.
    localparam logic RST_CONF_VALID = 1'b0;
    localparam int   RST_CONF_FIELD = 0;

    // Thread-id width. A single-thread build still needs a 1-bit field so
    // the port and RAM address concatenation stay legal.
    function automatic int calc_thread_w(input int num_threads);
        if (num_threads > 1) begin
            return $clog2(num_threads);
        end
        return 1;
    endfunction

endpackage

// File: rtl/branch_switch_pc_sequencer_branch_conf_ram.sv
// ---------------------------------------------------------------------------
// branch_conf_ram
//
// Simple dual-port RAM holding the switch configuration words for every
// thread. One write port and one synchronous read port. The read port is
// read-first: a read and a write to the same address in the same cycle
// returns the previous contents.
//
// The read data register is the sequencer's conf_data output stage, so it
// carries a read enable (it holds while downstream stalls) and is cleared
// by the active-low synchronous reset. The array itself is never reset.
//
// Parameters:
//   DEPTH  number of words
//   WIDTH  word width
//   AW     address width
//
// Ports:
//   clk    clock, rising edge
//   rst    synchronous reset, active-low (clears rdata only)
//   we     write enable
//   waddr  write address
//   wdata  write data
//   re     read enable, loads rdata on the next edge
//   raddr  read address
//   rdata  registered read data
// ---------------------------------------------------------------------------
module branch_conf_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 24,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port. Contents survive reset on purpose: configuration is
    // loaded once and reused across soft restarts.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port. Both processes use non-blocking updates, so a same-edge
    // write is not yet visible here and the old word is returned.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/branch_switch_pc_sequencer.sv
// ---------------------------------------------------------------------------
// branch_switch_pc_sequencer
//
// Per-thread program-counter sequencer and configuration store for one
// CGRA branch-network switch. Consumes the pc_max / pc_loop / net_mem
// write strobes from the configuration reader. Each accepted step request
// emits the stepped thread's current configuration word and advances that
// thread's PC, wrapping from pc_max back to pc_loop.
//
// Optional feature (macro BRANCH_LOOP_COUNT_EN):
//   Adds output conf_iter and a 16-bit per-thread counter that counts how
//   many times the thread's PC took the pc_max -> pc_loop wrap.
//
// Parameters:
//   NUM_THREADS  hardware thread count
//   ADDR_W       PC / instruction address width
//   CONF_W       configuration word width
//
// Ports:
//   clk            clock, rising edge
//   rst            synchronous reset, active-low
//   pc_max         loop-end PC, written for thread_id on pc_max_we
//   pc_max_we      pc_max write strobe
//   pc_loop        loop-start PC, written for thread_id on pc_loop_we
//   pc_loop_we     pc_loop write strobe
//   thread_id      target thread of all configuration writes
//   net_mem_we     configuration RAM write strobe
//   net_mem_waddr  configuration RAM address within thread
//   net_mem_data   configuration word to write
//   pc_restart     force every thread PC to 0
//   step_valid     step request
//   step_thread    thread to step
//   step_ready     step accepted when step_valid && step_ready
//   conf_valid     output word valid
//   conf_ready     downstream accepts the output word
//   conf_data      configuration word of the stepped thread
//   conf_thread    thread that produced conf_data
//   conf_iter      (BRANCH_LOOP_COUNT_EN only) wrap count after this step
//   conf_pc        PC that produced conf_data
// ---------------------------------------------------------------------------
module branch_switch_pc_sequencer
    import branch_switch_pc_sequencer_pkg::*;
#(
    parameter int  NUM_THREADS = 8,
    parameter int  ADDR_W      = 1,
    parameter int  CONF_W      = 24,
    localparam int THREAD_W    = calc_thread_w(NUM_THREADS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   pc_max,
    input  logic                pc_max_we,
    input  logic [ADDR_W-1:0]   pc_loop,
    input  logic                pc_loop_we,
    input  logic [THREAD_W-1:0] thread_id,
    input  logic                net_mem_we,
    input  logic [ADDR_W-1:0]   net_mem_waddr,
    input  logic [CONF_W-1:0]   net_mem_data,
    input  logic                pc_restart,
    input  logic                step_valid,
    input  logic [THREAD_W-1:0] step_thread,
    output logic                step_ready,
    output logic                conf_valid,
    input  logic                conf_ready,
    output logic [CONF_W-1:0]   conf_data,
    output logic [THREAD_W-1:0] conf_thread,
`ifdef BRANCH_LOOP_COUNT_EN
    output logic [ITER_W-1:0]   conf_iter,
`endif
    output logic [ADDR_W-1:0]   conf_pc
);

    localparam int PC_SLOTS  = 1 << ADDR_W;
    localparam int RAM_DEPTH = NUM_THREADS * PC_SLOTS;
    localparam int RAM_AW    = THREAD_W + ADDR_W;

    // Per-thread architectural state.
    logic [ADDR_W-1:0] pc_q      [NUM_THREADS];
    logic [ADDR_W-1:0] pc_max_q  [NUM_THREADS];
    logic [ADDR_W-1:0] pc_loop_q [NUM_THREADS];

    // Stepped-thread view of that state.
    logic [ADDR_W-1:0] cur_pc;
    logic [ADDR_W-1:0] cur_max;
    logic [ADDR_W-1:0] cur_loop;
    logic [ADDR_W-1:0] nxt_pc;
    logic              wrap_hit;
    logic              step_accept;

    // A new step may enter whenever the output register is empty or is
    // being drained this cycle. Restart and reset both block acceptance so
    // a step can never race the PC clear.
    assign step_ready  = rst && !pc_restart && (!conf_valid || conf_ready);
    assign step_accept = step_valid && step_ready;

    // Next-PC selection for the stepped thread. The comparison uses the
    // registered loop bounds, so a same-cycle config write only affects
    // later steps. With pc_loop > pc_max the increment simply wraps modulo
    // 2^ADDR_W until it reaches pc_max.
    always_comb begin
        cur_pc   = pc_q[step_thread];
        cur_max  = pc_max_q[step_thread];
        cur_loop = pc_loop_q[step_thread];
        wrap_hit = (cur_pc == cur_max);
        nxt_pc   = wrap_hit ? cur_loop : cur_pc + ADDR_W'(1);
    end

    // Loop bound registers. The two strobes are independent and may fire
    // together, for the same thread_id.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_THREADS; i++) begin
                pc_max_q[i]  <= '0;
                pc_loop_q[i] <= '0;
            end
        end else begin
            if (pc_max_we) begin
                pc_max_q[thread_id] <= pc_max;
            end
            if (pc_loop_we) begin
                pc_loop_q[thread_id] <= pc_loop;
            end
        end
    end

    // Program counters. Restart takes priority, although step_ready already
    // keeps a step from being accepted in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_THREADS; i++) begin
                pc_q[i] <= '0;
            end
        end else if (pc_restart) begin
            for (int i = 0; i < NUM_THREADS; i++) begin
                pc_q[i] <= '0;
            end
        end else if (step_accept) begin
            pc_q[step_thread] <= nxt_pc;
        end
    end

    // Output stage control. The word stays valid and stable until
    // downstream takes it. Restart leaves it alone. Reset drops it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            conf_valid  <= RST_CONF_VALID;
            conf_thread <= THREAD_W'(RST_CONF_FIELD);
            conf_pc     <= ADDR_W'(RST_CONF_FIELD);
        end else if (step_accept) begin
            conf_valid  <= 1'b1;
            conf_thread <= step_thread;
            conf_pc     <= cur_pc;
        end else if (conf_ready) begin
            conf_valid  <= 1'b0;
        end
    end

    // Configuration store. Its read register is the conf_data field of the
    // output stage, loaded only on an accepted step.
    branch_conf_ram #(
        .DEPTH (RAM_DEPTH),
        .WIDTH (CONF_W),
        .AW    (RAM_AW)
    ) u_conf_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (net_mem_we),
        .waddr ({thread_id, net_mem_waddr}),
        .wdata (net_mem_data),
        .re    (step_accept),
        .raddr ({step_thread, cur_pc}),
        .rdata (conf_data)
    );

`ifdef BRANCH_LOOP_COUNT_EN
    logic [ITER_W-1:0] iter_q [NUM_THREADS];
    logic [ITER_W-1:0] cur_iter;
    logic [ITER_W-1:0] iter_inc;

    // The counter of the stepped thread after this step. The +1 wraps
    // naturally from 0xFFFF to 0.
    always_comb begin
        cur_iter = iter_q[step_thread];
        iter_inc = cur_iter + ITER_W'(1);
    end

    // Per-thread wrap counters. Cleared by restart like the PCs, since a
    // restart starts every thread's loop from scratch.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_THREADS; i++) begin
                iter_q[i] <= '0;
            end
        end else if (pc_restart) begin
            for (int i = 0; i < NUM_THREADS; i++) begin
                iter_q[i] <= '0;
            end
        end else if (step_accept && wrap_hit) begin
            iter_q[step_thread] <= iter_inc;
        end
    end

    // Post-increment count, registered alongside conf_data so the two
    // always describe the same step.
    always_ff @(posedge clk) begin
        if (!rst) begin
            conf_iter <= ITER_W'(RST_CONF_FIELD);
        end else if (step_accept) begin
            conf_iter <= wrap_hit ? iter_inc : cur_iter;
        end
    end
`else
    // Loop counting disabled: no counters and no conf_iter port.
`endif

endmodule

// File: tb/tb_branch_switch_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_branch_switch_pc_sequencer
//
// Self-checking bench for branch_switch_pc_sequencer with default
// parameters. A behavioural model (plain arrays and modulo arithmetic)
// tracks thread PCs, loop bounds, RAM contents and the output register;
// table-driven sequences cover the directed scenarios, followed by a
// randomized phase. Build with BRANCH_LOOP_COUNT_EN defined to also check
// conf_iter.
// ---------------------------------------------------------------------------
module tb_branch_switch_pc_sequencer;

    localparam int NT     = 8;
    localparam int AW     = 1;
    localparam int CW     = 24;
    localparam int TW     = 3;
    localparam int PCS    = 1 << AW;
    localparam int CMASK  = (1 << CW) - 1;

    typedef struct {
        int thread;
        int exp_pc;
        int exp_data;
        bit use_data;
        int exp_iter;
    } vec_t;

    logic          clk;
    logic          rst;
    logic [AW-1:0] pc_max;
    logic          pc_max_we;
    logic [AW-1:0] pc_loop;
    logic          pc_loop_we;
    logic [TW-1:0] thread_id;
    logic          net_mem_we;
    logic [AW-1:0] net_mem_waddr;
    logic [CW-1:0] net_mem_data;
    logic          pc_restart;
    logic          step_valid;
    logic [TW-1:0] step_thread;
    logic          step_ready;
    logic          conf_valid;
    logic          conf_ready;
    logic [CW-1:0] conf_data;
    logic [TW-1:0] conf_thread;
    logic [AW-1:0] conf_pc;
`ifdef BRANCH_LOOP_COUNT_EN
    logic [15:0]   conf_iter;
`endif

    branch_switch_pc_sequencer #(
        .NUM_THREADS (NT),
        .ADDR_W      (AW),
        .CONF_W      (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_max        (pc_max),
        .pc_max_we     (pc_max_we),
        .pc_loop       (pc_loop),
        .pc_loop_we    (pc_loop_we),
        .thread_id     (thread_id),
        .net_mem_we    (net_mem_we),
        .net_mem_waddr (net_mem_waddr),
        .net_mem_data  (net_mem_data),
        .pc_restart    (pc_restart),
        .step_valid    (step_valid),
        .step_thread   (step_thread),
        .step_ready    (step_ready),
        .conf_valid    (conf_valid),
        .conf_ready    (conf_ready),
        .conf_data     (conf_data),
        .conf_thread   (conf_thread),
`ifdef BRANCH_LOOP_COUNT_EN
        .conf_iter     (conf_iter),
`endif
        .conf_pc       (conf_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_pass;

    // Behavioural model state.
    int m_pc   [NT];
    int m_max  [NT];
    int m_loop [NT];
    int m_iter [NT];
    int m_mem  [NT*PCS];
    bit m_valid;
    int m_data;
    int m_thr;
    int m_opc;
    int m_oiter;

    vec_t load_tab  [4];
    vec_t ilv_tab   [8];
    vec_t iter_tab  [6];

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic idleInputs();
        pc_max        = '0;
        pc_max_we     = 1'b0;
        pc_loop       = '0;
        pc_loop_we    = 1'b0;
        thread_id     = '0;
        net_mem_we    = 1'b0;
        net_mem_waddr = '0;
        net_mem_data  = '0;
        pc_restart    = 1'b0;
        step_valid    = 1'b0;
        step_thread   = '0;
    endtask

    task automatic modelReset();
        for (int i = 0; i < NT; i++) begin
            m_pc[i]   = 0;
            m_max[i]  = 0;
            m_loop[i] = 0;
            m_iter[i] = 0;
        end
        m_valid = 1'b0;
        m_data  = 0;
        m_thr   = 0;
        m_opc   = 0;
        m_oiter = 0;
    endtask

    // One clock cycle with the inputs as currently driven. Checks the
    // handshake before the edge, advances the model, then checks outputs.
    task automatic stepCycle(input string tag);
        bit exp_ready;
        bit acc;
        bit wrap;
        int t;
        int p;
        #1;
        exp_ready = rst && !pc_restart && (!m_valid || conf_ready);
        checkOutput({tag, "/step_ready"}, 32'(step_ready), 32'(exp_ready));
        acc = step_valid && exp_ready;
        if (!rst) begin
            modelReset();
        end else begin
            if (acc) begin
                t    = int'(step_thread);
                p    = m_pc[t];
                wrap = (p == m_max[t]);
                m_data = m_mem[t*PCS + p];
                m_opc  = p;
                m_thr  = t;
                if (wrap) m_iter[t] = (m_iter[t] + 1) % 65536;
                m_oiter = m_iter[t];
                m_pc[t] = wrap ? m_loop[t] : (p + 1) % PCS;
                m_valid = 1'b1;
            end else if (conf_ready) begin
                m_valid = 1'b0;
            end
            if (pc_restart) begin
                for (int i = 0; i < NT; i++) begin
                    m_pc[i]   = 0;
                    m_iter[i] = 0;
                end
            end
            if (pc_max_we)  m_max[int'(thread_id)]  = int'(pc_max);
            if (pc_loop_we) m_loop[int'(thread_id)] = int'(pc_loop);
        end
        if (net_mem_we) m_mem[int'(thread_id)*PCS + int'(net_mem_waddr)] = int'(net_mem_data);
        @(posedge clk);
        #1;
        checkOutput({tag, "/conf_valid"},  32'(conf_valid),  32'(m_valid));
        checkOutput({tag, "/conf_data"},   32'(conf_data),   32'(m_data));
        checkOutput({tag, "/conf_thread"}, 32'(conf_thread), 32'(m_thr));
        checkOutput({tag, "/conf_pc"},     32'(conf_pc),     32'(m_opc));
`ifdef BRANCH_LOOP_COUNT_EN
        checkOutput({tag, "/conf_iter"},   32'(conf_iter),   32'(m_oiter));
`endif
    endtask

    task automatic writeMem(input int t, input int a, input int d);
        thread_id     = TW'(t);
        net_mem_waddr = AW'(a);
        net_mem_data  = CW'(d);
        net_mem_we    = 1'b1;
        stepCycle("wr_mem");
        net_mem_we    = 1'b0;
    endtask

    task automatic writeLoop(input int t, input int mx, input int lp);
        thread_id  = TW'(t);
        pc_max     = AW'(mx);
        pc_loop    = AW'(lp);
        pc_max_we  = 1'b1;
        pc_loop_we = 1'b1;
        stepCycle("wr_loop");
        pc_max_we  = 1'b0;
        pc_loop_we = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        step_valid  = 1'b1;
        step_thread = TW'(v.thread);
    endtask

    task automatic checkVec(input string tag, input vec_t v);
        checkOutput({tag, "/tab_pc"},     32'(conf_pc),     32'(v.exp_pc));
        checkOutput({tag, "/tab_thread"}, 32'(conf_thread), 32'(v.thread));
        if (v.use_data) begin
            checkOutput({tag, "/tab_data"}, 32'(conf_data), 32'(v.exp_data));
        end
    endtask

    initial begin
        int old_word;
        n_checks = 0;
        n_pass   = 0;
        for (int i = 0; i < NT*PCS; i++) m_mem[i] = 0;

        load_tab[0] = '{2, 0, 32'hAAAAAA, 1'b1, 0};
        load_tab[1] = '{2, 1, 32'h555555, 1'b1, 0};
        load_tab[2] = '{2, 0, 32'hAAAAAA, 1'b1, 0};
        load_tab[3] = '{2, 1, 32'h555555, 1'b1, 0};

        // t0: pc_max=1, pc_loop=1 -> 0,1,1,1 ; t7: pc_max=0, pc_loop=1 -> 0,1,0,1
        ilv_tab[0] = '{0, 0, 0, 1'b0, 0};
        ilv_tab[1] = '{7, 0, 0, 1'b0, 0};
        ilv_tab[2] = '{0, 1, 0, 1'b0, 0};
        ilv_tab[3] = '{7, 1, 0, 1'b0, 0};
        ilv_tab[4] = '{0, 1, 0, 1'b0, 0};
        ilv_tab[5] = '{7, 0, 0, 1'b0, 0};
        ilv_tab[6] = '{0, 1, 0, 1'b0, 0};
        ilv_tab[7] = '{7, 1, 0, 1'b0, 0};

        iter_tab[0] = '{5, 0, 0, 1'b0, 0};
        iter_tab[1] = '{5, 1, 0, 1'b0, 1};
        iter_tab[2] = '{5, 0, 0, 1'b0, 1};
        iter_tab[3] = '{5, 1, 0, 1'b0, 2};
        iter_tab[4] = '{5, 0, 0, 1'b0, 2};
        iter_tab[5] = '{5, 1, 0, 1'b0, 3};

        // Reset
        idleInputs();
        conf_ready = 1'b1;
        rst = 1'b0;
        modelReset();
        stepCycle("reset");
        stepCycle("reset");
        rst = 1'b1;
        #1;
        checkOutput("post_reset/step_ready", 32'(step_ready), 32'd1);

        // Fill the whole RAM with known random words
        for (int t = 0; t < NT; t++) begin
            for (int a = 0; a < PCS; a++) begin
                writeMem(t, a, int'($urandom) & CMASK);
            end
        end

        // Reset then load, back-to-back steps on t2
        writeMem(2, 0, 32'hAAAAAA);
        writeMem(2, 1, 32'h555555);
        writeLoop(2, 1, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(load_tab[i]);
            stepCycle("load");
            checkVec("load", load_tab[i]);
        end
        step_valid = 1'b0;
        stepCycle("drain");

        // Backpressure on t2 (pc back at 0)
        conf_ready  = 1'b0;
        step_valid  = 1'b1;
        step_thread = 3'd2;
        stepCycle("bp_first");
        for (int i = 0; i < 3; i++) begin
            stepCycle("bp_hold");
            checkOutput("bp_hold/data", 32'(conf_data), 32'hAAAAAA);
            checkOutput("bp_hold/pc",   32'(conf_pc),   32'd0);
        end
        conf_ready = 1'b1;
        stepCycle("bp_release");
        checkOutput("bp_release/data", 32'(conf_data), 32'h555555);
        checkOutput("bp_release/pc",   32'(conf_pc),   32'd1);
        stepCycle("bp_next");
        checkOutput("bp_next/data", 32'(conf_data), 32'hAAAAAA);
        step_valid = 1'b0;
        stepCycle("drain");

        // Same-cycle write and read of RAM[t0,0] (t0 still pinned at pc 0)
        old_word      = m_mem[0];
        step_valid    = 1'b1;
        step_thread   = 3'd0;
        thread_id     = 3'd0;
        net_mem_waddr = 1'b0;
        net_mem_data  = 24'h123456;
        net_mem_we    = 1'b1;
        stepCycle("rw_same");
        checkOutput("rw_same/old_data", 32'(conf_data), 32'(old_word));
        net_mem_we = 1'b0;
        stepCycle("rw_next");
        checkOutput("rw_next/new_data", 32'(conf_data), 32'h123456);
        step_valid = 1'b0;
        stepCycle("drain");

        // Interleaved threads with different loop bounds
        writeLoop(0, 1, 1);
        writeLoop(7, 0, 1);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(ilv_tab[i]);
            stepCycle("interleave");
            checkVec("interleave", ilv_tab[i]);
        end
        step_valid = 1'b0;
        stepCycle("drain");

        // pc_restart with t3 at pc 1
        writeLoop(3, 1, 0);
        step_valid  = 1'b1;
        step_thread = 3'd3;
        stepCycle("rs_pre");
        conf_ready = 1'b0;
        pc_restart = 1'b1;
        stepCycle("rs_hold");
        checkOutput("rs_hold/conf_valid", 32'(conf_valid), 32'd1);
        pc_restart = 1'b0;
        conf_ready = 1'b1;
        stepCycle("rs_after");
        checkOutput("rs_after/pc", 32'(conf_pc), 32'd0);
        step_valid = 1'b0;
        stepCycle("drain");

        // Wrap counting sequence on t5
        writeLoop(5, 1, 0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(iter_tab[i]);
            stepCycle("iter");
            checkVec("iter", iter_tab[i]);
`ifdef BRANCH_LOOP_COUNT_EN
            checkOutput("iter/tab_iter", 32'(conf_iter), 32'(iter_tab[i].exp_iter));
`endif
        end
        step_valid = 1'b0;
        stepCycle("drain");

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            step_valid    = ($urandom_range(0, 3) != 0);
            step_thread   = TW'($urandom_range(0, NT-1));
            conf_ready    = ($urandom_range(0, 3) != 0);
            pc_restart    = ($urandom_range(0, 29) == 0);
            thread_id     = TW'($urandom_range(0, NT-1));
            pc_max        = AW'($urandom_range(0, PCS-1));
            pc_loop       = AW'($urandom_range(0, PCS-1));
            pc_max_we     = ($urandom_range(0, 5) == 0);
            pc_loop_we    = ($urandom_range(0, 5) == 0);
            net_mem_waddr = AW'($urandom_range(0, PCS-1));
            net_mem_data  = CW'($urandom);
            net_mem_we    = ($urandom_range(0, 4) == 0);
            stepCycle("random");
        end
        idleInputs();
        conf_ready = 1'b1;
        stepCycle("drain");

        // Reset with a word in flight
        conf_ready  = 1'b0;
        step_valid  = 1'b1;
        step_thread = 3'd2;
        stepCycle("rst_pre");
        checkOutput("rst_pre/conf_valid", 32'(conf_valid), 32'd1);
        rst = 1'b0;
        stepCycle("rst_mid");
        checkOutput("rst_mid/conf_valid", 32'(conf_valid), 32'd0);
        rst        = 1'b1;
        conf_ready = 1'b1;
        stepCycle("rst_resume");
        stepCycle("rst_resume");
        step_valid = 1'b0;
        stepCycle("drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
